// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared types and constants for the HI/LO multiply-divide sequencer.
//   md_op_e    - execute-stage op codes (MD_NOP .. MD_MTLO, 7 reserved)
//   md_state_e - sequencer states (idle / divider busy / multiplier busy)
//   DIV0_LO    - LO value produced by the divide-by-zero fast path
package muldiv_pkg;

    typedef enum logic [2:0] {
        MD_NOP   = 3'd0,
        MD_MULT  = 3'd1,
        MD_MULTU = 3'd2,
        MD_DIV   = 3'd3,
        MD_DIVU  = 3'd4,
        MD_MTHI  = 3'd5,
        MD_MTLO  = 3'd6,
        MD_RSVD  = 3'd7
    } md_op_e;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_DIV_BUSY = 2'd1,
        ST_MUL_BUSY = 2'd2
    } md_state_e;

    localparam logic [31:0] DIV0_LO = 32'hFFFF_FFFF;

    function automatic logic is_div_op(input md_op_e op);
        return (op == MD_DIV) || (op == MD_DIVU);
    endfunction

    function automatic logic is_mul_op(input md_op_e op);
        return (op == MD_MULT) || (op == MD_MULTU);
    endfunction

endpackage

// File: rtl/md_engine_port.sv
// md_engine_port: operand/sign latch and validIn generation for one multi-cycle
// engine (divider or multiplier).
//   clk, resetn      clock, asynchronous active-low reset
//   load             capture load_a/load_b/load_sign this edge
//   load_sign/a/b    operands presented by the sequencer
//   busy             sequencer is waiting on this engine
//   valid_out        engine reports completion
//   valid_in         engine request (busy & ~valid_out)
//   sign, src_a/b    latched operands, constant while busy
module md_engine_port
    import muldiv_pkg::*;
(
    input  logic        clk,
    input  logic        resetn,
    input  logic        load,
    input  logic        load_sign,
    input  logic [31:0] load_a,
    input  logic [31:0] load_b,
    input  logic        busy,
    input  logic        valid_out,
    output logic        valid_in,
    output logic        sign,
    output logic [31:0] src_a,
    output logic [31:0] src_b
);

    logic        sign_reg;
    logic [31:0] src_a_reg;
    logic [31:0] src_b_reg;

    // Operands only change on a new accept; the engine re-reads them for its
    // final sign correction, so they must hold for the whole busy period.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            sign_reg  <= 1'b0;
            src_a_reg <= '0;
            src_b_reg <= '0;
        end else if (load) begin
            sign_reg  <= load_sign;
            src_a_reg <= load_a;
            src_b_reg <= load_b;
        end
    end

    // Combinational drop on completion: the engine must never see validIn
    // while it sits idle after finishing, or it would restart.
    assign valid_in = busy & ~valid_out;
    assign sign     = sign_reg;
    assign src_a    = src_a_reg;
    assign src_b    = src_b_reg;

endmodule

// File: rtl/muldiv_ctrl.sv
// muldiv_ctrl: sequencer for the HI/LO multiply-divide resource.
// Accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO, drives the divider and multiplier
// through validIn/validOut, owns architectural HI/LO and stalls the pipeline
// while an operation is in flight.
//   clk, resetn                 clock, asynchronous active-low reset
//   op_valid/op_code/op_a/op_b  execute-stage op; op_ready = accepted
//   rd_req, stall, flush        MFHI/MFLO request, pipeline stall, cancel
//   hi, lo                      architectural HI/LO
//   div_* / mul_*               engine handshakes, latched operands, results
// Optional build macro MULDIV_DIV0_FASTPATH_EN: a DIV/DIVU with op_b == 0
// completes at the accept edge with hi = op_a, lo = DIV0_LO.
module muldiv_ctrl
    import muldiv_pkg::*;
(
    input  logic        clk,
    input  logic        resetn,
    input  logic        op_valid,
    input  logic [2:0]  op_code,
    input  logic [31:0] op_a,
    input  logic [31:0] op_b,
    output logic        op_ready,
    input  logic        rd_req,
    output logic        stall,
    input  logic        flush,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        div_validIn,
    output logic        div_sign,
    output logic [31:0] div_SrcA,
    output logic [31:0] div_SrcB,
    input  logic        div_validOut,
    input  logic [31:0] div_Hi,
    input  logic [31:0] div_Lo,
    output logic        mul_validIn,
    output logic        mul_sign,
    output logic [31:0] mul_SrcA,
    output logic [31:0] mul_SrcB,
    input  logic        mul_validOut,
    input  logic [31:0] mul_Hi,
    input  logic [31:0] mul_Lo
);

    md_state_e   state_reg, state_next;
    md_op_e      op;
    logic        idle;
    logic        div0_fast;
    logic        div_load, mul_load;
    logic        hi_we, lo_we;
    logic [31:0] hi_next, lo_next;
    logic [31:0] hi_reg, lo_reg;

    assign op   = md_op_e'(op_code);
    assign idle = (state_reg == ST_IDLE);

`ifdef MULDIV_DIV0_FASTPATH_EN
    assign div0_fast = (op_b == 32'd0);
`else
    assign div0_fast = 1'b0;
`endif

    // State register
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) state_reg <= ST_IDLE;
        else         state_reg <= state_next;
    end

    // Next-state logic; flush takes priority over a same-cycle completion.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: begin
                if (op_valid) begin
                    if (is_mul_op(op))                    state_next = ST_MUL_BUSY;
                    else if (is_div_op(op) && !div0_fast) state_next = ST_DIV_BUSY;
                end
            end
            ST_DIV_BUSY: if (flush || div_validOut) state_next = ST_IDLE;
            ST_MUL_BUSY: if (flush || mul_validOut) state_next = ST_IDLE;
            default:     state_next = ST_IDLE;
        endcase
    end

    // Output / datapath-control logic
    always_comb begin
        op_ready = idle;
        stall    = ~idle & (op_valid | rd_req);
        div_load = 1'b0;
        mul_load = 1'b0;
        hi_we    = 1'b0;
        lo_we    = 1'b0;
        hi_next  = hi_reg;
        lo_next  = lo_reg;
        case (state_reg)
            ST_IDLE: begin
                if (op_valid) begin
                    case (op)
                        MD_MULT, MD_MULTU: mul_load = 1'b1;
                        MD_DIV, MD_DIVU: begin
                            if (div0_fast) begin
                                hi_we   = 1'b1;
                                lo_we   = 1'b1;
                                hi_next = op_a;
                                lo_next = DIV0_LO;
                            end else begin
                                div_load = 1'b1;
                            end
                        end
                        MD_MTHI: begin
                            hi_we   = 1'b1;
                            hi_next = op_a;
                        end
                        MD_MTLO: begin
                            lo_we   = 1'b1;
                            lo_next = op_a;
                        end
                        default: ;
                    endcase
                end
            end
            ST_DIV_BUSY: begin
                if (div_validOut && !flush) begin
                    hi_we   = 1'b1;
                    lo_we   = 1'b1;
                    hi_next = div_Hi;
                    lo_next = div_Lo;
                end
            end
            ST_MUL_BUSY: begin
                if (mul_validOut && !flush) begin
                    hi_we   = 1'b1;
                    lo_we   = 1'b1;
                    hi_next = mul_Hi;
                    lo_next = mul_Lo;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            hi_reg <= '0;
            lo_reg <= '0;
        end else begin
            if (hi_we) hi_reg <= hi_next;
            if (lo_we) lo_reg <= lo_next;
        end
    end

    assign hi = hi_reg;
    assign lo = lo_reg;

    md_engine_port u_div_port (
        .clk       (clk),
        .resetn    (resetn),
        .load      (div_load),
        .load_sign (op == MD_DIV),
        .load_a    (op_a),
        .load_b    (op_b),
        .busy      (state_reg == ST_DIV_BUSY),
        .valid_out (div_validOut),
        .valid_in  (div_validIn),
        .sign      (div_sign),
        .src_a     (div_SrcA),
        .src_b     (div_SrcB)
    );

    md_engine_port u_mul_port (
        .clk       (clk),
        .resetn    (resetn),
        .load      (mul_load),
        .load_sign (op == MD_MULT),
        .load_a    (op_a),
        .load_b    (op_b),
        .busy      (state_reg == ST_MUL_BUSY),
        .valid_out (mul_validOut),
        .valid_in  (mul_validIn),
        .sign      (mul_sign),
        .src_a     (mul_SrcA),
        .src_b     (mul_SrcB)
    );

endmodule

// File: tb/tb_muldiv_ctrl.sv
// tb_muldiv_ctrl: self-checking bench for muldiv_ctrl. Models the divider and
// multiplier engines (random latency, stale validOut pulses while idle) and
// keeps an architectural model of HI/LO and the in-flight operation.
module tb_muldiv_ctrl;
    import muldiv_pkg::*;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        resetn;
    logic        op_valid, rd_req, flush;
    logic [2:0]  op_code;
    logic [31:0] op_a, op_b;
    logic        op_ready, stall;
    logic [31:0] hi, lo;
    logic        div_validIn, div_sign, div_validOut;
    logic [31:0] div_SrcA, div_SrcB, div_Hi, div_Lo;
    logic        mul_validIn, mul_sign, mul_validOut;
    logic [31:0] mul_SrcA, mul_SrcB, mul_Hi, mul_Lo;

    muldiv_ctrl dut (
        .clk(clk), .resetn(resetn),
        .op_valid(op_valid), .op_code(op_code), .op_a(op_a), .op_b(op_b),
        .op_ready(op_ready), .rd_req(rd_req), .stall(stall), .flush(flush),
        .hi(hi), .lo(lo),
        .div_validIn(div_validIn), .div_sign(div_sign),
        .div_SrcA(div_SrcA), .div_SrcB(div_SrcB),
        .div_validOut(div_validOut), .div_Hi(div_Hi), .div_Lo(div_Lo),
        .mul_validIn(mul_validIn), .mul_sign(mul_sign),
        .mul_SrcA(mul_SrcA), .mul_SrcB(mul_SrcB),
        .mul_validOut(mul_validOut), .mul_Hi(mul_Hi), .mul_Lo(mul_Lo)
    );

    int n_vec  = 0;
    int n_miss = 0;

    // Inputs to apply in the next cycle
    logic        n_op_valid, n_rd_req, n_flush;
    logic [2:0]  n_op_code;
    logic [31:0] n_op_a, n_op_b;
    logic        op_held;

    // Engine models: outputs for the next cycle plus progress counters
    logic        e_dvo, e_mvo;
    logic [31:0] e_dhi, e_dlo, e_mhi, e_mlo;
    int          d_cnt, d_lat, m_cnt, m_lat;

    // Architectural model: 0 = nothing in flight, 1 = divide, 2 = multiply
    int          m_busy;
    logic [31:0] m_hi, m_lo, m_da, m_db, m_ma, m_mb;
    logic        m_ds, m_ms;

    // Divider contract: {remainder, quotient}; x/0 gives rem=x, quo=all ones.
    function automatic logic [63:0] div_ref(input logic [31:0] a, input logic [31:0] b,
                                            input logic s);
        logic [31:0] q, r;
        if (b == 32'd0) begin
            q = 32'hFFFF_FFFF;
            r = a;
        end else if (s && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            q = a;
            r = 32'd0;
        end else if (s) begin
            q = $signed(a) / $signed(b);
            r = $signed(a) % $signed(b);
        end else begin
            q = a / b;
            r = a % b;
        end
        return {r, q};
    endfunction

    function automatic logic [63:0] mul_ref(input logic [31:0] a, input logic [31:0] b,
                                            input logic s);
        logic [63:0] xa, xb;
        xa = s ? {{32{a[31]}}, a} : {32'd0, a};
        xb = s ? {{32{b[31]}}, b} : {32'd0, b};
        return xa * xb;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison of every meaningful DUT output against the model
    task automatic check_cycle();
        chk("op_ready", 32'(op_ready), 32'(m_busy == 0));
        chk("stall", 32'(stall), 32'((m_busy != 0) && (op_valid || rd_req)));
        chk("hi", hi, m_hi);
        chk("lo", lo, m_lo);
        chk("div_validIn", 32'(div_validIn), 32'((m_busy == 1) && !div_validOut));
        chk("mul_validIn", 32'(mul_validIn), 32'((m_busy == 2) && !mul_validOut));
        if (m_busy == 1) begin
            chk("div_SrcA", div_SrcA, m_da);
            chk("div_SrcB", div_SrcB, m_db);
            chk("div_sign", 32'(div_sign), 32'(m_ds));
        end
        if (m_busy == 2) begin
            chk("mul_SrcA", mul_SrcA, m_ma);
            chk("mul_SrcB", mul_SrcB, m_mb);
            chk("mul_sign", 32'(mul_sign), 32'(m_ms));
        end
    endtask

    task automatic model_update();
        logic [63:0] res;
        op_held = op_valid && (m_busy != 0);
        if (m_busy == 0) begin
            if (op_valid) begin
                case (op_code)
                    MD_MULT, MD_MULTU: begin
                        m_busy = 2; m_ma = op_a; m_mb = op_b; m_ms = (op_code == MD_MULT);
                    end
                    MD_DIV, MD_DIVU: begin
`ifdef MULDIV_DIV0_FASTPATH_EN
                        if (op_b == 32'd0) begin
                            m_hi = op_a; m_lo = 32'hFFFF_FFFF;
                        end else begin
                            m_busy = 1; m_da = op_a; m_db = op_b; m_ds = (op_code == MD_DIV);
                        end
`else
                        m_busy = 1; m_da = op_a; m_db = op_b; m_ds = (op_code == MD_DIV);
`endif
                    end
                    MD_MTHI: m_hi = op_a;
                    MD_MTLO: m_lo = op_a;
                    default: ;
                endcase
            end
        end else if (flush) begin
            m_busy = 0;
        end else if (m_busy == 1 && div_validOut) begin
            res = div_ref(m_da, m_db, m_ds);
            m_hi = res[63:32]; m_lo = res[31:0]; m_busy = 0;
        end else if (m_busy == 2 && mul_validOut) begin
            res = mul_ref(m_ma, m_mb, m_ms);
            m_hi = res[63:32]; m_lo = res[31:0]; m_busy = 0;
        end
    endtask

    // Engines react to the DUT's actual request and operands. Stale pulses
    // are only injected when the sequencer will not be waiting on that engine.
    task automatic engine_update();
        logic [63:0] res;
        if (div_validIn && !div_validOut) begin
            d_cnt++;
            e_dvo = 1'b0;
            if (d_cnt >= d_lat) begin
                res = div_ref(div_SrcA, div_SrcB, div_sign);
                e_dvo = 1'b1; e_dhi = res[63:32]; e_dlo = res[31:0];
                d_cnt = 0; d_lat = $urandom_range(1, 6);
            end
        end else begin
            d_cnt = 0;
            e_dvo = (m_busy != 1) && ($urandom_range(0, 5) == 0);
            e_dhi = $urandom; e_dlo = $urandom;
        end
        if (mul_validIn && !mul_validOut) begin
            m_cnt++;
            e_mvo = 1'b0;
            if (m_cnt >= m_lat) begin
                res = mul_ref(mul_SrcA, mul_SrcB, mul_sign);
                e_mvo = 1'b1; e_mhi = res[63:32]; e_mlo = res[31:0];
                m_cnt = 0; m_lat = $urandom_range(1, 6);
            end
        end else begin
            m_cnt = 0;
            e_mvo = (m_busy != 2) && ($urandom_range(0, 5) == 0);
            e_mhi = $urandom; e_mlo = $urandom;
        end
    endtask

    // One clock cycle: drive after the edge, compare at the falling edge.
    task automatic step();
        @(posedge clk); #1;
        op_valid = n_op_valid; op_code = n_op_code; op_a = n_op_a; op_b = n_op_b;
        rd_req = n_rd_req; flush = n_flush;
        div_validOut = e_dvo; div_Hi = e_dhi; div_Lo = e_dlo;
        mul_validOut = e_mvo; mul_Hi = e_mhi; mul_Lo = e_mlo;
        @(negedge clk);
        check_cycle();
        model_update();
        engine_update();
    endtask

    task automatic issue(input logic [2:0] code, input logic [31:0] a, input logic [31:0] b);
        n_op_valid = 1'b1; n_op_code = code; n_op_a = a; n_op_b = b;
        step();
        n_op_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int k = 0;
        while (m_busy != 0 && k < 50) begin
            step();
            k++;
        end
        if (m_busy != 0) begin
            n_vec++; n_miss++;
            $display("FAIL wait_idle: still busy after %0d cycles, expected idle", k);
            m_busy = 0;
        end
    endtask

    task automatic clear_inputs();
        n_op_valid = 0; n_op_code = 0; n_op_a = 0; n_op_b = 0; n_rd_req = 0; n_flush = 0;
        e_dvo = 0; e_dhi = 0; e_dlo = 0; e_mvo = 0; e_mhi = 0; e_mlo = 0;
        d_cnt = 0; m_cnt = 0; op_held = 0;
    endtask

    initial begin
        resetn = 1'b0;
        op_valid = 0; op_code = 0; op_a = 0; op_b = 0; rd_req = 0; flush = 0;
        div_validOut = 0; div_Hi = 0; div_Lo = 0;
        mul_validOut = 0; mul_Hi = 0; mul_Lo = 0;
        clear_inputs();
        d_lat = 3; m_lat = 3;
        m_busy = 0; m_hi = 0; m_lo = 0;
        m_da = 0; m_db = 0; m_ma = 0; m_mb = 0; m_ds = 0; m_ms = 0;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_hi", hi, 32'd0);
        chk("rst_lo", lo, 32'd0);
        chk("rst_op_ready", 32'(op_ready), 32'd1);
        chk("rst_div_validIn", 32'(div_validIn), 32'd0);
        chk("rst_mul_validIn", 32'(mul_validIn), 32'd0);
        chk("rst_div_SrcA", div_SrcA, 32'd0);
        chk("rst_mul_SrcB", mul_SrcB, 32'd0);
        resetn = 1'b1;

        // MTHI then MTLO back to back
        issue(MD_MTHI, 32'h1234, 32'd0);
        chk("mt_stall0", 32'(stall), 32'd0);
        issue(MD_MTLO, 32'h5678, 32'd0);
        chk("mt_stall1", 32'(stall), 32'd0);
        step();
        chk("mthi_val", hi, 32'h1234);
        chk("mtlo_val", lo, 32'h5678);

        // Signed divide -7 / 2 with an MFHI waiting
        issue(MD_DIV, 32'hFFFF_FFF9, 32'd2);
        n_rd_req = 1'b1;
        step();
        chk("div_rd_stall", 32'(stall), 32'd1);
        wait_idle();
        n_rd_req = 1'b0;
        step();
        chk("div_m7_hi", hi, 32'hFFFF_FFFF);
        chk("div_m7_lo", lo, 32'hFFFF_FFFD);

        // DIVU 100/7 then MULTU 3*5 issued the cycle after completion
        issue(MD_DIVU, 32'd100, 32'd7);
        wait_idle();
        issue(MD_MULTU, 32'd3, 32'd5);
        chk("divu_hi", hi, 32'd2);
        chk("divu_lo", lo, 32'd14);
        wait_idle();
        step();
        chk("multu_hi", hi, 32'd0);
        chk("multu_lo", lo, 32'd15);

        // Flush three cycles into DIV 50/5
        d_lat = 10;
        issue(MD_DIV, 32'd50, 32'd5);
        step();
        step();
        n_flush = 1'b1;
        step();
        n_flush = 1'b0;
        step();
        chk("flush_validIn", 32'(div_validIn), 32'd0);
        chk("flush_hi", hi, 32'd0);
        chk("flush_lo", lo, 32'd15);

        // Asynchronous reset in the middle of a divide
        d_lat = 10;
        issue(MD_DIV, 32'd1000, 32'd3);
        step();
        step();
        #2 resetn = 1'b0;
        #1;
        chk("arst_hi", hi, 32'd0);
        chk("arst_lo", lo, 32'd0);
        chk("arst_op_ready", 32'(op_ready), 32'd1);
        chk("arst_div_validIn", 32'(div_validIn), 32'd0);
        clear_inputs();
        div_validOut = 1'b0; mul_validOut = 1'b0;
        m_busy = 0; m_hi = 0; m_lo = 0;
        @(posedge clk); #1;
        chk("arst_div_validIn_next", 32'(div_validIn), 32'd0);
        @(negedge clk);
        resetn = 1'b1;
        d_lat = 3;

        // Divide by zero
        issue(MD_DIV, 32'd9, 32'd0);
`ifdef MULDIV_DIV0_FASTPATH_EN
        chk("div0_no_busy", 32'(m_busy), 32'd0);
`else
        wait_idle();
`endif
        step();
        chk("div0_hi", hi, 32'd9);
        chk("div0_lo", lo, 32'hFFFF_FFFF);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            if (!op_held) begin
                n_op_valid = ($urandom_range(0, 2) != 0);
                n_op_code  = 3'($urandom_range(0, 7));
                n_op_a     = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 300)) : $urandom;
                case ($urandom_range(0, 7))
                    0:       n_op_b = 32'd0;
                    1, 2:    n_op_b = 32'($urandom_range(1, 20));
                    default: n_op_b = $urandom;
                endcase
            end
            n_rd_req = ($urandom_range(0, 3) == 0);
            n_flush  = (m_busy != 0) && ($urandom_range(0, 15) == 0);
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
